// File: rtl/i_type_alu_if.sv
// Instr_IO: bundles the instruction, operands and results exchanged with the
// RV32I OP-IMM execute unit. The I_type_io_ports modport is the execute unit's
// (slave) view; the master modport is the view of whoever drives operands.
interface Instr_IO;
  logic [31:0] idata;
  logic [31:0] iaddr;
  logic [31:0] imm;
  logic [31:0] rv1;
  logic [31:0] rv2;
  logic [31:0] regdata_I;
  logic        valid_I;
  logic        illegal_I;
  logic [31:0] regdata_q;
  logic [31:0] iaddr_q;
  logic        valid_q;

  modport I_type_io_ports (
    input  idata, iaddr, imm, rv1, rv2,
    output regdata_I, valid_I, illegal_I, regdata_q, iaddr_q, valid_q
  );

  modport master (
    output idata, iaddr, imm, rv1, rv2,
    input  regdata_I, valid_I, illegal_I, regdata_q, iaddr_q, valid_q
  );
endinterface

// File: rtl/i_type_alu.sv
// i_type_alu: RV32I OP-IMM execute unit (ADDI..SRAI).
// The write-back data is purely combinational so the single-cycle core can
// retire in the same cycle; a one-cycle registered copy of the result, PC and
// valid flag is kept for trace/debug only.
module i_type_alu #(
  parameter int         XLEN         = 32,
  parameter logic [6:0] OPCODE_OPIMM = 7'b0010011
) (
  input logic              clk,
  input logic              reset,
  Instr_IO.I_type_io_ports io
);

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      shamt;
  logic            isOpImm;
  logic            badShift;
  logic [XLEN-1:0] resultD;
  logic            unusedBits;

  // Only funct3, instruction bit 30 and the low five immediate bits steer the
  // datapath, so opcode/funct7 garbage can never disturb the result.
  assign funct3 = io.idata[14:12];
  assign funct7 = io.idata[31:25];
  assign shamt  = io.imm[4:0];

  // rs2 and the rd/rs1 register fields are decoded elsewhere in the core.
  assign unusedBits = ^{io.rv2, io.idata[24:15], io.idata[11:7]};

  // Result mux: one arithmetic/logic operation per funct3, bit 30 picks SRA vs SRL.
  always_comb begin
    resultD = '0;
    case (funct3)
      3'b000: resultD = io.rv1 + io.imm;
      3'b010: resultD = {{(XLEN-1){1'b0}}, ($signed(io.rv1) < $signed(io.imm))};
      3'b011: resultD = {{(XLEN-1){1'b0}}, (io.rv1 < io.imm)};
      3'b100: resultD = io.rv1 ^ io.imm;
      3'b110: resultD = io.rv1 | io.imm;
      3'b111: resultD = io.rv1 & io.imm;
      3'b001: resultD = io.rv1 << shamt;
      3'b101: begin
        if (io.idata[30]) begin
          resultD = $unsigned($signed(io.rv1) >>> shamt);
        end else begin
          resultD = io.rv1 >> shamt;
        end
      end
      default: resultD = '0;
    endcase
  end

  // Legality: only the shift encodings constrain funct7; everything else in
  // the OP-IMM space is legal regardless of the upper instruction bits.
  always_comb begin
    isOpImm  = (io.idata[6:0] == OPCODE_OPIMM);
    badShift = 1'b0;
    if (funct3 == 3'b001) begin
      badShift = (funct7 != 7'b0000000);
    end else if (funct3 == 3'b101) begin
      badShift = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
    end
  end

  assign io.regdata_I = resultD;
  assign io.illegal_I = isOpImm && badShift;
  assign io.valid_I   = isOpImm && !badShift;

  // Trace register: captures result, PC and validity one cycle later; reset
  // clears only these copies, never the combinational outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      io.regdata_q <= '0;
      io.iaddr_q   <= '0;
      io.valid_q   <= 1'b0;
    end else begin
      io.regdata_q <= io.regdata_I;
      io.iaddr_q   <= io.iaddr;
      io.valid_q   <= io.valid_I;
    end
  end

endmodule

// File: tb/tb_i_type_alu.sv
// tb_i_type_alu: table-driven check of the OP-IMM execute unit. Combinational
// outputs are compared 1 ns after each input change; expected trace-register
// contents are queued when stimulus is driven and compared after the edge.
module tb_i_type_alu;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  Instr_IO io ();

  i_type_alu dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rv1;
    logic [31:0] imm;
    logic [31:0] expData;
    logic        expValid;
    logic        expIllegal;
  } vecT;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        valid;
  } regExpT;

  vecT    vecs[$];
  regExpT sbQ[$];

  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] OPREG = 7'b0110011;

  function automatic vecT mkVec(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [31:0] a, logic [31:0] b, logic [31:0] d,
                                logic v, logic il);
    vecT r;
    r.name = n; r.opcode = op; r.funct3 = f3; r.funct7 = f7;
    r.rv1 = a; r.imm = b; r.expData = d; r.expValid = v; r.expIllegal = il;
    return r;
  endfunction

  task automatic checkOutput(string n, logic [31:0] actual, logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", n, actual, expected);
    end
  endtask

  // Drive one instruction on the negedge, check the combinational outputs and
  // queue the trace-register contents the next edge must produce.
  task automatic applyStimulus(vecT v, logic [31:0] pc);
    regExpT e;
    @(negedge clk);
    io.idata = {v.funct7, 5'd3, 5'd1, v.funct3, 5'd2, v.opcode};
    io.iaddr = pc;
    io.rv1   = v.rv1;
    io.imm   = v.imm;
    io.rv2   = $urandom;
    #1;
    checkOutput({v.name, ".regdata_I"}, io.regdata_I, v.expData);
    checkOutput({v.name, ".valid_I"}, {31'b0, io.valid_I}, {31'b0, v.expValid});
    checkOutput({v.name, ".illegal_I"}, {31'b0, io.illegal_I}, {31'b0, v.expIllegal});
    if (reset) begin
      e.data = '0; e.addr = '0; e.valid = 1'b0;
    end else begin
      e.data = v.expData; e.addr = pc; e.valid = v.expValid;
    end
    sbQ.push_back(e);
  endtask

  // Wait past the next rising edge and compare the oldest queued expectation.
  task automatic checkRegs(string n);
    regExpT e;
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s.queue: got empty expected entry", n);
    end else begin
      e = sbQ.pop_front();
      checkOutput({n, ".regdata_q"}, io.regdata_q, e.data);
      checkOutput({n, ".iaddr_q"}, io.iaddr_q, e.addr);
      checkOutput({n, ".valid_q"}, {31'b0, io.valid_q}, {31'b0, e.valid});
    end
  endtask

  initial begin
    vecT v;
    total = 0;
    bad   = 0;

    vecs.push_back(mkVec("addi",      OPIMM, 3'b000, 7'h00, 32'd617, 32'd511, 32'd1128, 1'b1, 1'b0));
    vecs.push_back(mkVec("addiWrap",  OPIMM, 3'b000, 7'h7f, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mkVec("slti0",     OPIMM, 3'b010, 7'h00, 32'd989, 32'd295, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mkVec("sltiNeg",   OPIMM, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b1, 1'b0));
    vecs.push_back(mkVec("sltiNegImm",OPIMM, 3'b010, 7'h00, 32'd5, 32'hFFFFFFFD, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mkVec("sltiu0",    OPIMM, 3'b011, 7'h00, 32'd980, 32'd533, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mkVec("sltiuBig",  OPIMM, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mkVec("sltiuImm",  OPIMM, 3'b011, 7'h00, 32'd5, 32'hFFFFFFFD, 32'd1, 1'b1, 1'b0));
    vecs.push_back(mkVec("xori",      OPIMM, 3'b100, 7'h00, 32'd679, 32'd91, 32'd764, 1'b1, 1'b0));
    vecs.push_back(mkVec("ori",       OPIMM, 3'b110, 7'h00, 32'd234, 32'd592, 32'd762, 1'b1, 1'b0));
    vecs.push_back(mkVec("andi",      OPIMM, 3'b111, 7'h00, 32'd503, 32'd746, 32'd226, 1'b1, 1'b0));
    vecs.push_back(mkVec("slli",      OPIMM, 3'b001, 7'h00, 32'd843, 32'd750, 32'd13811712, 1'b1, 1'b0));
    vecs.push_back(mkVec("srliBig",   OPIMM, 3'b101, 7'h00, 32'd949, 32'd372, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mkVec("sraiBig",   OPIMM, 3'b101, 7'h20, 32'd949, 32'd372, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mkVec("srliMsb",   OPIMM, 3'b101, 7'h00, 32'h80000000, 32'd4, 32'h08000000, 1'b1, 1'b0));
    vecs.push_back(mkVec("sraiMsb",   OPIMM, 3'b101, 7'h20, 32'h80000000, 32'h404, 32'hF8000000, 1'b1, 1'b0));
    vecs.push_back(mkVec("sraiZero",  OPIMM, 3'b101, 7'h20, 32'h80000001, 32'd0, 32'h80000001, 1'b1, 1'b0));
    vecs.push_back(mkVec("slliBad",   OPIMM, 3'b001, 7'h20, 32'd3, 32'd2, 32'd12, 1'b0, 1'b1));
    vecs.push_back(mkVec("srliBad",   OPIMM, 3'b101, 7'h01, 32'hF0, 32'd4, 32'h0F, 1'b0, 1'b1));
    vecs.push_back(mkVec("notOpImm",  OPREG, 3'b000, 7'h00, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0));
    vecs.push_back(mkVec("notOpSlli", OPREG, 3'b001, 7'h20, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0));

    io.idata = '0; io.iaddr = '0; io.rv1 = '0; io.imm = '0; io.rv2 = '0;

    // Reset held across one edge clears the trace registers.
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset.regdata_q", io.regdata_q, 32'd0);
    checkOutput("reset.iaddr_q", io.iaddr_q, 32'd0);
    checkOutput("reset.valid_q", {31'b0, io.valid_q}, 32'd0);

    // Release and retire ADDI 617+511 through the trace register.
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(vecs[0], 32'h0000_0100);
    checkRegs("postReset");

    // Table sweep, one instruction per cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], 32'h0000_1000 + 32'(i * 4));
      checkRegs(vecs[i].name);
    end

    // Mid-stream reset: combinational result still valid, trace regs cleared.
    applyStimulus(vecs[8], 32'h0000_2000);
    checkRegs("beforeMidReset");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(vecs[9], 32'h0000_2004);
    checkRegs("midReset");
    @(negedge clk);
    reset = 1'b0;
    v = mkVec("afterMidReset", OPIMM, 3'b101, 7'h20, 32'hFFFFFF00, 32'd8, 32'hFFFFFFFF, 1'b1, 1'b0);
    applyStimulus(v, 32'h0000_2008);
    checkRegs("afterMidReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
